// File: rtl/net_rx.sv
// RGMII receive byte engine: strips preamble/SFD, frames payload+FCS, flags length/er/CRC errors.
// Optional CRC-32 checking is compiled in when NET_RX_CRC_EN is defined.
module net_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic       clk125,
    input  logic       rst,
    input  logic [3:0] rxd_r,
    input  logic [3:0] rxd_f,
    input  logic       rxctl_r,
    input  logic       rxctl_f,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       out_err,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t          state;
    logic [7:0]      in_byte;
    logic            in_dv;
    logic            in_er;
    logic            armed;
    logic [LW-1:0]   len;
    logic [7:0]      hold;
    logic            sticky_er;
    logic            inc_ok;
    logic            inc_err;
    logic            final_err;

`ifdef NET_RX_CRC_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    always_comb begin
        final_err = sticky_er | (len < LW'(MIN_LEN));
`ifdef NET_RX_CRC_EN
        final_err = final_err | (crc != 32'hDEBB20E3);
`endif
    end

    // out_valid is a one-cycle strobe per byte with no backpressure; out_last/out_err qualify it.
    always_ff @(posedge clk125) begin
        if (rst) begin
            in_byte   <= 8'h00;
            in_dv     <= 1'b1;   // a frame in flight at reset release must not look like a gap
            in_er     <= 1'b0;
            armed     <= 1'b0;
            state     <= IDLE;
            len       <= '0;
            hold      <= 8'h00;
            sticky_er <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            inc_ok    <= 1'b0;
            inc_err   <= 1'b0;
            cnt_ok    <= 16'h0000;
            cnt_err   <= 16'h0000;
`ifdef NET_RX_CRC_EN
            crc       <= 32'hFFFFFFFF;
`endif
        end else begin
            in_byte <= {rxd_f, rxd_r};
            in_dv   <= rxctl_r;
            in_er   <= rxctl_r ^ rxctl_f;
            if (!in_dv) armed <= 1'b1;

            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            inc_ok    <= 1'b0;
            inc_err   <= 1'b0;
            // Counters trail the last beat by one cycle.
            if (inc_ok)  cnt_ok  <= cnt_ok + 16'd1;
            if (inc_err) cnt_err <= cnt_err + 16'd1;

            case (state)
                IDLE: begin
                    if (in_dv && in_byte == 8'h55 && armed) state <= PRE;
                end
                PRE: begin
                    if (!in_dv) begin
                        state <= IDLE;
                    end else if (in_byte == 8'hD5) begin
                        state     <= DATA;
                        len       <= '0;
                        sticky_er <= 1'b0;
`ifdef NET_RX_CRC_EN
                        crc       <= 32'hFFFFFFFF;
`endif
                    end else if (in_byte != 8'h55) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (!in_dv) begin
                        state <= IDLE;
                        if (len == '0) begin
                            inc_err <= 1'b1;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= hold;
                            out_last  <= 1'b1;
                            out_err   <= final_err;
                            inc_ok    <= ~final_err;
                            inc_err   <= final_err;
                        end
                    end else if (len == LW'(MAX_LEN)) begin
                        state     <= DROP;
                        out_valid <= 1'b1;
                        out_data  <= hold;
                        out_last  <= 1'b1;
                        out_err   <= 1'b1;
                        inc_err   <= 1'b1;
                    end else begin
                        hold <= in_byte;
                        len  <= len + 1'b1;
                        if (in_er) sticky_er <= 1'b1;
`ifdef NET_RX_CRC_EN
                        crc  <= crc_byte(crc, in_byte);
`endif
                        if (len != '0) begin
                            out_valid <= 1'b1;
                            out_data  <= hold;
                        end
                    end
                end
                DROP: begin
                    if (!in_dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_net_rx.sv
// Scoreboard bench for net_rx: driver pushes expected beats, a negedge monitor pops and compares.
module tb_net_rx;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;
`ifdef NET_RX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rxd_r = 4'h0;
    logic [3:0]  rxd_f = 4'h0;
    logic        rxctl_r = 1'b0;
    logic        rxctl_f = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_err;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    net_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk125(clk125), .rst(rst), .rxd_r(rxd_r), .rxd_f(rxd_f),
        .rxctl_r(rxctl_r), .rxctl_f(rxctl_f), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_err(out_err),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    always #4 clk125 = ~clk125;

    int cyc = 0;
    always @(posedge clk125) cyc <= cyc + 1;

    logic [9:0] exp_q[$];
    int         exp_cyc_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_ok = 0;
    int         exp_err = 0;
    logic [7:0] fb [0:1599];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc32(input int m);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < m; i++) begin
            b = fb[i];
            for (int k = 0; k < 8; k++) begin
                if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Frame is CRC-good when its last four bytes are the FCS of the rest, LSB first.
    function automatic bit fcs_ok(input int n);
        logic [31:0] f;
        if (n < 4) return 1'b0;
        f = crc32(n - 4);
        return fb[n-4] == f[7:0] && fb[n-3] == f[15:8] && fb[n-2] == f[23:16] && fb[n-1] == f[31:24];
    endfunction

    task automatic build_good(input int n);
        logic [31:0] f;
        for (int i = 0; i < n - 4; i++) fb[i] = 8'($urandom_range(0, 255));
        f = crc32(n - 4);
        fb[n-4] = f[7:0];
        fb[n-3] = f[15:8];
        fb[n-2] = f[23:16];
        fb[n-1] = f[31:24];
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] b);
        @(posedge clk125);
        #1;
        rxd_r   = b[3:0];
        rxd_f   = b[7:4];
        rxctl_r = dv;
        rxctl_f = dv ^ er;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input int n, input int er_idx, input int rst_idx, input int gap);
        int beats;
        bit err;
        bit aborted;
        bit last;
        aborted = 1'b0;
        beats = (n > MAX_LEN) ? MAX_LEN : n;
        err = (n > MAX_LEN) || (n < MIN_LEN) || (er_idx >= 0 && er_idx < beats) ||
              (CRC_ON && !fcs_ok(n));
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, (i == er_idx), fb[i]);
            rst = (i == rst_idx);
            if (i == rst_idx) begin
                aborted = 1'b1;
                while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
                    void'(exp_q.pop_back());
                    void'(exp_cyc_q.pop_back());
                end
                exp_ok  = 0;
                exp_err = 0;
            end
            if (!aborted && i < beats) begin
                last = (i == beats - 1);
                exp_q.push_back({last, last & err, fb[i]});
                exp_cyc_q.push_back(cyc + 3);
            end
        end
        rst = 1'b0;
        if (!aborted) begin
            if (err) exp_err++;
            else exp_ok++;
        end
        idle(gap);
    endtask

    task automatic check_counters();
        idle(6);
        check("cnt_ok", {16'h0, cnt_ok}, 32'(exp_ok[15:0]));
        check("cnt_err", {16'h0, cnt_err}, 32'(exp_err[15:0]));
    endtask

    logic [9:0] mon_e;
    int         mon_c;
    always @(negedge clk125) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h last %0b err %0b expected none (cycle %0d)",
                         out_data, out_last, out_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("beat", {22'h0, out_last, out_err, out_data}, {22'h0, mon_e});
                check("beat_cycle", cyc, mon_c);
            end
        end
    end

    initial begin
        int n;
        int kind;
        int er_idx;
        rst = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'h0);
        check("rst_cnt_ok", {16'h0, cnt_ok}, 32'h0);
        check("rst_cnt_err", {16'h0, cnt_err}, 32'h0);
        rst = 1'b0;
        idle(3);

        build_good(64);
        send_frame(64, -1, -1, 4);
        check_counters();

        fb[10] = fb[10] ^ 8'h04;
        send_frame(64, -1, -1, 4);
        check_counters();

        build_good(64);
        send_frame(64, 20, -1, 4);
        check_counters();

        build_good(60);
        send_frame(60, -1, -1, 4);
        check_counters();

        for (int i = 0; i < 1600; i++) fb[i] = 8'($urandom_range(0, 255));
        send_frame(1600, -1, -1, 4);
        check_counters();
        build_good(64);
        send_frame(64, -1, -1, 4);
        check_counters();

        build_good(MAX_LEN);
        send_frame(MAX_LEN, -1, -1, 2);
        check_counters();

        send_frame(0, -1, -1, 3);
        check_counters();

        // Preamble aborted by a foreign byte, then a preamble cut short by a gap.
        repeat (3) drive(1'b1, 1'b0, 8'h55);
        repeat (10) drive(1'b1, 1'b0, 8'h12);
        idle(1);
        repeat (4) drive(1'b1, 1'b0, 8'h55);
        idle(1);
        check_counters();

        repeat (14) begin
            n = $urandom_range(1, 160);
            kind = $urandom_range(0, 3);
            if (n >= 4) build_good(n);
            else for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
            if (kind == 1) fb[$urandom_range(0, n - 1)] ^= 8'(1 << $urandom_range(0, 7));
            er_idx = (kind == 2) ? $urandom_range(0, n - 1) : -1;
            if (n < 40) n = n + 60;
            if (n >= 64 && kind == 0) build_good(n);
            send_frame(n, er_idx, -1, $urandom_range(1, 3));
        end
        check_counters();

        build_good(64);
        send_frame(64, -1, 30, 4);
        check_counters();
        build_good(64);
        send_frame(64, -1, -1, 4);
        check_counters();

        idle(10);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
